// File: rtl/prod_accum.sv
// prod_accum: length-programmed accumulator for a stream of 8-bit products.
// Three-state job FSM with a clipping ACC_W-bit sum and a per-job sticky sat flag.
module prod_accum #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       len,
  input  logic [7:0]       p,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [4:0]       cnt;
  logic [ACC_W:0]   sum;
  logic             xfer;
  logic             last;

  assign xfer = (state == RUN) && p_valid;
  assign last = xfer && (cnt == 5'd1);
  // one spare bit catches any carry out of the accumulator
  assign sum  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, p};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      sat <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt <= (len == 4'd0) ? 5'd16 : {1'b0, len};
      acc <= '0;
      sat <= 1'b0;
    end else if (xfer) begin
      cnt <= cnt - 5'd1;
      if (sum[ACC_W]) begin
        acc <= '1;
        sat <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

  always_comb begin
    p_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: ;
      RUN: begin
        p_ready = 1'b1;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed checks of prod_accum.
// Wide instance covers job flow; an 8-bit instance covers clipping.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic [7:0]  p;
  logic        p_valid;
  logic        p_ready;
  logic [11:0] acc;
  logic        busy;
  logic        done;
  logic        sat;

  logic        start8;
  logic [3:0]  len8;
  logic [7:0]  p8;
  logic        p_valid8;
  logic        p_ready8;
  logic [7:0]  acc8;
  logic        busy8;
  logic        done8;
  logic        sat8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .p(p), .p_valid(p_valid), .p_ready(p_ready),
    .acc(acc), .busy(busy), .done(done), .sat(sat)
  );

  prod_accum #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .len(len8),
    .p(p8), .p_valid(p_valid8), .p_ready(p_ready8),
    .acc(acc8), .busy(busy8), .done(done8), .sat(sat8)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] v);
    p_valid = 1'b1;
    p = v;
    tick();
    p_valid = 1'b0;
  endtask

  task automatic feed8(input logic [7:0] v);
    p_valid8 = 1'b1;
    p8 = v;
    tick();
    p_valid8 = 1'b0;
  endtask

  task automatic go(input logic [3:0] n);
    start = 1'b1;
    len = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; len = 0; p = 0; p_valid = 0;
    start8 = 0; len8 = 0; p8 = 0; p_valid8 = 0;
    #3;
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", p_ready, 0);
    chk("rst_sat", sat, 0);
    tick();
    rst_n = 1'b1;

    // basic job: 4 x 225
    go(4'd4);
    chk("b_ready", p_ready, 1);
    chk("b_busy", busy, 1);
    chk("b_acc0", acc, 0);
    for (int i = 0; i < 4; i++) feed(8'd225);
    chk("b_done", done, 1);
    chk("b_acc", acc, 900);
    chk("b_busyd", busy, 0);
    chk("b_readyd", p_ready, 0);
    chk("b_sat", sat, 0);
    tick();
    chk("b_done1", done, 0);
    chk("b_hold", acc, 900);
    chk("b_ready1", p_ready, 0);

    // len=0 means 16 products
    go(4'd0);
    for (int i = 0; i < 15; i++) feed(8'd225);
    chk("z_busy15", busy, 1);
    chk("z_acc15", acc, 3375);
    feed(8'd225);
    chk("z_done", done, 1);
    chk("z_acc", acc, 3600);
    p_valid = 1'b1;
    chk("z_ready17", p_ready, 0);
    tick();
    p_valid = 1'b0;
    chk("z_acc17", acc, 3600);
    chk("z_done1", done, 0);
    chk("z_ready18", p_ready, 0);

    // bubbles: gaps 0, 2, 5
    go(4'd3);
    feed(8'd10);
    tick(); tick();
    feed(8'd20);
    for (int i = 0; i < 5; i++) tick();
    chk("u_busy", busy, 1);
    chk("u_hold", acc, 30);
    feed(8'd30);
    chk("u_done", done, 1);
    chk("u_acc", acc, 60);
    tick();
    chk("u_done1", done, 0);

    // start during RUN is ignored
    go(4'd2);
    start = 1'b1;
    len = 4'd9;
    feed(8'd7);
    start = 1'b0;
    feed(8'd8);
    chk("i_done", done, 1);
    chk("i_acc", acc, 15);
    tick();
    chk("i_busy", busy, 0);
    chk("i_done1", done, 0);

    // saturation on 8-bit instance
    start8 = 1'b1;
    len8 = 4'd2;
    tick();
    start8 = 1'b0;
    feed8(8'd200);
    chk("s_acc1", acc8, 200);
    chk("s_sat1", sat8, 0);
    feed8(8'd100);
    chk("s_done", done8, 1);
    chk("s_acc", acc8, 255);
    chk("s_sat", sat8, 1);
    tick();
    chk("s_sathold", sat8, 1);
    start8 = 1'b1;
    len8 = 4'd1;
    tick();
    start8 = 1'b0;
    chk("s_clr", sat8, 0);
    chk("s_acc0", acc8, 0);
    feed8(8'd5);
    chk("s_acc2", acc8, 5);
    chk("s_sat2", sat8, 0);
    tick();

    // reset mid-job
    go(4'd5);
    feed(8'd1);
    feed(8'd2);
    chk("r_acc2", acc, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("r_acc", acc, 0);
    chk("r_busy", busy, 0);
    chk("r_ready", p_ready, 0);
    tick();
    chk("r_done", done, 0);
    rst_n = 1'b1;
    go(4'd1);
    chk("r_busy2", busy, 1);
    feed(8'd9);
    chk("r_done2", done, 1);
    chk("r_acc9", acc, 9);
    tick();
    chk("r_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
